// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared axis state type, 640x480@60 defaults and total helper
// Purpose: common definitions imported by vga_axis_counter and vga_timing_gen.
// Ports: none (package).
package vga_timing_pkg;

    typedef enum logic [1:0] {
        S_ACTIVE,
        S_FRONT,
        S_SYNC,
        S_BACK
    } axis_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Largest axis length representable by the 10-bit position counters.
    localparam int AXIS_MAX     = 1024;

    function automatic int axis_total(input int a, input int fp, input int s, input int bp);
        return a + fp + s + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one scan axis: position counter plus ACTIVE/FRONT/SYNC/BACK FSM
// Purpose: counts 0..TOTAL-1 on each step and tracks which segment the count is in.
// Ports: vga_clk clock; reset_n async active-low reset; step advance enable;
//        count current position; state segment of count; wrap high on the step that
//        takes count from TOTAL-1 back to 0.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        step,
    output logic [9:0]  count,
    output axis_state_t state,
    output logic        wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    // Last count of each segment; the FSM leaves a segment on the step taken from here.
    localparam logic [9:0] END_A = 10'(ACTIVE - 1);
    localparam logic [9:0] END_F = 10'(ACTIVE + FP - 1);
    localparam logic [9:0] END_S = 10'(ACTIVE + FP + SYNC - 1);
    localparam logic [9:0] END_B = 10'(TOTAL - 1);

    assign wrap = step && (count == END_B);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            state <= S_ACTIVE;
        end else if (step) begin
            count <= wrap ? 10'd0 : count + 10'd1;
            case (state)
                S_ACTIVE: if (count == END_A) state <= S_FRONT;
                S_FRONT:  if (count == END_F) state <= S_SYNC;
                S_SYNC:   if (count == END_S) state <= S_BACK;
                S_BACK:   if (wrap)           state <= S_ACTIVE;
                default:                      state <= S_ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA scan position, delayed syncs and frame event strobes
// Purpose: drives the scan position for all renderers, with hs/vs delayed to match
//          their registered RGB output.
// Ports: vga_clk pixel clock; reset_n async active-low reset; pix_en advance enable;
//        DrawX/DrawY scan position; blank 1 in the visible region; hs/vs delayed syncs;
//        line_start/frame_start/vblank_start one-cycle strobes; frame_count frames done.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_ACT   = 1'b0,
    parameter int SYNC_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        pix_en,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > AXIS_MAX || V_TOTAL > AXIS_MAX) begin : g_bad_size
            $error("vga_timing_gen: axis total exceeds 10-bit counter range");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be 0..3");
        end
    endgenerate

    axis_state_t w_h_state;
    axis_state_t w_v_state;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_v_step;
    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic        w_hs_raw;
    logic        w_vs_raw;

    assign w_v_step = pix_en & w_h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .step    (pix_en),
        .count   (DrawX),
        .state   (w_h_state),
        .wrap    (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .step    (w_v_step),
        .count   (DrawY),
        .state   (w_v_state),
        .wrap    (w_v_wrap)
    );

    // Position the counters will hold after this edge; decoding from it keeps the
    // registered flags aligned with the DrawX/DrawY pair they are shown with.
    assign w_x_next = w_h_wrap ? 10'd0 : DrawX + 10'd1;
    assign w_y_next = w_v_wrap ? 10'd0 : (w_h_wrap ? DrawY + 10'd1 : DrawY);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank        <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else if (pix_en) begin
            blank        <= (w_x_next < 10'(H_ACTIVE)) && (w_y_next < 10'(V_ACTIVE));
            line_start   <= (w_x_next == 10'd0);
            frame_start  <= (w_x_next == 10'd0) && (w_y_next == 10'd0);
            vblank_start <= (w_x_next == 10'd0) && (w_y_next == 10'(V_ACTIVE));
            if (w_v_wrap) begin
                frame_count <= frame_count + 16'd1;
            end
        end else begin
            // Stalled cycles never re-announce an event; blank keeps its value.
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end
    end

    assign w_hs_raw = (w_h_state == S_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    assign w_vs_raw = (w_v_state == S_SYNC) ? SYNC_ACT : ~SYNC_ACT;

    generate
        if (SYNC_DELAY == 0) begin : g_sync_direct
            assign hs = w_hs_raw;
            assign vs = w_vs_raw;
        end else begin : g_sync_pipe
            logic [SYNC_DELAY-1:0] r_hs_sr;
            logic [SYNC_DELAY-1:0] r_vs_sr;

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_hs_sr <= {SYNC_DELAY{~SYNC_ACT}};
                    r_vs_sr <= {SYNC_DELAY{~SYNC_ACT}};
                end else if (pix_en) begin
                    r_hs_sr <= (r_hs_sr << 1) | SYNC_DELAY'(w_hs_raw);
                    r_vs_sr <= (r_vs_sr << 1) | SYNC_DELAY'(w_vs_raw);
                end
            end

            assign hs = r_hs_sr[SYNC_DELAY-1];
            assign vs = r_vs_sr[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VA = 6, VFP = 2, VS = 2, VBP = 3;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic        vbs;
        logic [15:0] fc;
    } obs_t;

    localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1,
                                 ls: 1'b0, fs: 1'b0, vbs: 1'b0, fc: 16'd0};

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_en  = 1'b0;
    logic [9:0]  DrawX, DrawY;
    logic        blank, hs, vs, line_start, frame_start, vblank_start;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t sb_q[$];
    obs_t mon_exp, mon_got;

    int          m_x, m_y;
    logic        m_blank, m_hs, m_vs;
    logic [15:0] m_fc;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_ACT (1'b0), .SYNC_DELAY (1)
    ) dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .pix_en       (pix_en),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank        (blank),
        .hs           (hs),
        .vs           (vs),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .frame_count  (frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t obs_now();
        return {DrawX, DrawY, blank, hs, vs, line_start, frame_start, vblank_start, frame_count};
    endfunction

    // Scoreboard: one expectation per driven cycle, compared just after the edge.
    always @(posedge vga_clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_got = obs_now();
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b vb=%b fc=%0d, expected x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b vb=%b fc=%0d",
                         $time, mon_got.x, mon_got.y, mon_got.blank, mon_got.hs, mon_got.vs,
                         mon_got.ls, mon_got.fs, mon_got.vbs, mon_got.fc,
                         mon_exp.x, mon_exp.y, mon_exp.blank, mon_exp.hs, mon_exp.vs,
                         mon_exp.ls, mon_exp.fs, mon_exp.vbs, mon_exp.fc);
            end
        end
    end

    task automatic model_reset();
        m_x = 0; m_y = 0; m_blank = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_fc = 16'd0;
    endtask

    // Drive one cycle at the falling edge, push the expected post-edge outputs, and
    // return shortly after the rising edge so callers can sample settled outputs.
    task automatic step(input logic en);
        obs_t e;
        @(negedge vga_clk);
        pix_en = en;
        e.ls = 1'b0; e.fs = 1'b0; e.vbs = 1'b0;
        if (en) begin
            // Sync outputs show the previous position's sync region (one-stage delay).
            m_hs = !(m_x >= HA + HFP && m_x < HA + HFP + HS);
            m_vs = !(m_y >= VA + VFP && m_y < VA + VFP + VS);
            if (m_x == HT - 1) begin
                m_x = 0;
                if (m_y == VT - 1) begin
                    m_y = 0;
                    m_fc = m_fc + 16'd1;
                end else begin
                    m_y = m_y + 1;
                end
            end else begin
                m_x = m_x + 1;
            end
            m_blank = (m_x < HA) && (m_y < VA);
            e.ls  = (m_x == 0);
            e.fs  = (m_x == 0) && (m_y == 0);
            e.vbs = (m_x == 0) && (m_y == VA);
        end
        e.x = 10'(m_x); e.y = 10'(m_y); e.blank = m_blank;
        e.hs = m_hs; e.vs = m_vs; e.fc = m_fc;
        sb_q.push_back(e);
        @(posedge vga_clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pix_en  = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        n_checks++;
        if (obs_now() !== RST_OBS) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs_now(), RST_OBS);
        end
        @(negedge vga_clk);
        pix_en  = 1'b0;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_line();
        int first_low_x = -1;
        int rise_x      = -1;
        int low_cnt     = 0;
        step(1'b1);
        n_checks++;
        if (DrawX !== 10'd1 || DrawY !== 10'd0 || blank !== 1'b1) begin
            n_fail++;
            $display("FAIL first_cycle: got x=%0d y=%0d blank=%b expected x=1 y=0 blank=1", DrawX, DrawY, blank);
        end
        for (int i = 0; i < HT + 50; i++) begin
            step(1'b1);
            if (DrawY == 10'd0 && DrawX == 10'(HA - 1)) begin
                n_checks++;
                if (blank !== 1'b1) begin
                    n_fail++;
                    $display("FAIL blank_639: got %b expected 1", blank);
                end
            end
            if (DrawY == 10'd0 && DrawX == 10'(HA)) begin
                n_checks++;
                if (blank !== 1'b0) begin
                    n_fail++;
                    $display("FAIL blank_640: got %b expected 0", blank);
                end
            end
            if (hs === 1'b0) begin
                low_cnt++;
                if (first_low_x < 0) first_low_x = int'(DrawX);
            end else if (first_low_x >= 0 && rise_x < 0) begin
                rise_x = int'(DrawX);
            end
        end
        n_checks++;
        if (first_low_x != HA + HFP + 1) begin
            n_fail++;
            $display("FAIL hs_fall: got DrawX=%0d expected %0d", first_low_x, HA + HFP + 1);
        end
        n_checks++;
        if (low_cnt != HS) begin
            n_fail++;
            $display("FAIL hs_width: got %0d expected %0d", low_cnt, HS);
        end
        n_checks++;
        if (rise_x != HA + HFP + HS + 1) begin
            n_fail++;
            $display("FAIL hs_rise: got DrawX=%0d expected %0d", rise_x, HA + HFP + HS + 1);
        end
    endtask

    task automatic test_frame();
        int cnt = 0, ls_cnt = 0, vbs_cnt = 0, vs_low = 0;
        logic [15:0] fc0;
        while (frame_start !== 1'b1 && cnt < 2 * FRAME) begin
            step(1'b1);
            cnt++;
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_sync: got no frame_start within %0d cycles, expected one", 2 * FRAME);
            return;
        end
        fc0 = frame_count;
        cnt = 0;
        do begin
            step(1'b1);
            cnt++;
            if (line_start === 1'b1) ls_cnt++;
            if (vs === 1'b0) vs_low++;
            if (vblank_start === 1'b1) begin
                vbs_cnt++;
                n_checks++;
                if (DrawX !== 10'd0 || DrawY !== 10'(VA)) begin
                    n_fail++;
                    $display("FAIL vblank_pos: got x=%0d y=%0d expected x=0 y=%0d", DrawX, DrawY, VA);
                end
            end
        end while (frame_start !== 1'b1 && cnt < 2 * FRAME);
        n_checks++;
        if (cnt != FRAME) begin
            n_fail++;
            $display("FAIL frame_period: got %0d expected %0d", cnt, FRAME);
        end
        n_checks++;
        if (vs_low != VS * HT) begin
            n_fail++;
            $display("FAIL vs_width: got %0d expected %0d", vs_low, VS * HT);
        end
        n_checks++;
        if (ls_cnt != VT) begin
            n_fail++;
            $display("FAIL line_start_count: got %0d expected %0d", ls_cnt, VT);
        end
        n_checks++;
        if (vbs_cnt != 1) begin
            n_fail++;
            $display("FAIL vblank_count: got %0d expected 1", vbs_cnt);
        end
        n_checks++;
        if (frame_count !== fc0 + 16'd1) begin
            n_fail++;
            $display("FAIL frame_count_inc: got %0d expected %0d", frame_count, fc0 + 16'd1);
        end
    endtask

    task automatic test_stall();
        int   cnt = 0, ls_cnt = 0;
        obs_t hold;
        logic [9:0] y0;
        while (DrawX !== 10'(HT - 1) && cnt < 2 * HT) begin
            step(1'b1);
            cnt++;
        end
        n_checks++;
        if (DrawX !== 10'(HT - 1)) begin
            n_fail++;
            $display("FAIL stall_reach: got DrawX=%0d expected %0d", DrawX, HT - 1);
            return;
        end
        hold = obs_now();
        hold.ls = 1'b0; hold.fs = 1'b0; hold.vbs = 1'b0;
        y0 = DrawY;
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            n_checks++;
            if (obs_now() !== hold) begin
                n_fail++;
                $display("FAIL stall_hold %0d: got %h expected %h", i, obs_now(), hold);
            end
        end
        step(1'b1);
        n_checks++;
        if (DrawX !== 10'd0 || DrawY !== 10'((int'(y0) + 1) % VT)) begin
            n_fail++;
            $display("FAIL stall_resume: got x=%0d y=%0d expected x=0 y=%0d", DrawX, DrawY, (int'(y0) + 1) % VT);
        end
        if (line_start === 1'b1) ls_cnt++;
        repeat (3) begin
            step(1'b1);
            if (line_start === 1'b1) ls_cnt++;
        end
        n_checks++;
        if (ls_cnt != 1) begin
            n_fail++;
            $display("FAIL stall_line_start: got %0d strobes expected 1", ls_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        while (!(DrawX === 10'd300 && DrawY === 10'd3) && cnt < 2 * FRAME) begin
            step(1'b1);
            cnt++;
        end
        n_checks++;
        if (!(DrawX === 10'd300 && DrawY === 10'd3) || frame_count === 16'd0) begin
            n_fail++;
            $display("FAIL midreset_reach: got x=%0d y=%0d fc=%0d expected x=300 y=3 fc>0", DrawX, DrawY, frame_count);
            return;
        end
        @(negedge vga_clk);
        pix_en = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs_now() !== RST_OBS) begin
            n_fail++;
            $display("FAIL midreset_async: got %h expected %h", obs_now(), RST_OBS);
        end
        @(negedge vga_clk);
        reset_n = 1'b1;
        pix_en  = 1'b0;
        model_reset();
        for (int i = 0; i < HT + 20; i++) step(1'b1);
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame();
        test_stall();
        test_reset_mid();
        repeat (3) @(posedge vga_clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
